board_pixel_pipeline: RTL and testbench
=======================================

BOARD_PIXEL_PIPELINE -- requirements
Module: board_pixel_pipeline

Interface
REQ-001 SHALL have parameter COLS, default 10, meaning board columns.
REQ-002 SHALL have parameter ROWS, default 10, meaning board rows.
REQ-003 SHALL have parameter TILE_LOG2, default 5, meaning tile edge = 2^TILE_LOG2 pixels.
REQ-004 SHALL have parameters ORG_X, default 176, and ORG_Y, default 32, meaning the board's top-left pixel.
REQ-005 SHALL have parameter CW, default 2, meaning cell-code width.
REQ-006 SHALL have parameter RGB_W, default 3, meaning colour width.
REQ-007 SHALL have parameters BG_COLOR, default 3'b111, and HL_COLOR, default 3'b100.
REQ-008 SHALL have parameter BLINK_LOG2, default 4, meaning frames per blink half-period = 2^BLINK_LOG2.
REQ-009 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-010 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-011 SHALL have ports pix_valid (input, 1), x (input, 16) and y (input, 16), meaning the pixel request.
REQ-012 SHALL have port frame_start, input, 1, meaning a one-cycle pulse per frame.
REQ-013 SHALL have ports board_addr (output, AW = clog2(COLS*ROWS)) and board_data (input, CW), meaning the board RAM; read latency is 1 cycle.
REQ-014 SHALL have ports sprite_addr (output, CW+2*TILE_LOG2) and sprite_data (input, RGB_W), meaning the sprite ROM; read latency is 1 cycle.
REQ-015 SHALL have ports hl_en (input, 1), hl_col (input, 8) and hl_row (input, 8), meaning the highlighted tile.
REQ-016 SHALL have ports blink_en (input, 1) and blink_code (input, CW), meaning the blinking cell code.
REQ-017 SHALL have ports rgb (output, RGB_W) and rgb_valid (output, 1), meaning the output pixel.

Function
REQ-018 SHALL compute in_board = (x>=ORG_X) && (x<ORG_X+COLS*2^TILE_LOG2) && (y>=ORG_Y) && (y<ORG_Y+ROWS*2^TILE_LOG2), using unsigned compares.
REQ-019 SHALL derive col, row, off_x and off_y as follows: col = (x-ORG_X)>>TILE_LOG2, off_x = low TILE_LOG2 bits of (x-ORG_X); row and off_y are derived likewise from y.
REQ-020 SHALL register board_addr = row*COLS+col one edge after the pixel is sampled (E0 -> E1).
REQ-021 SHALL hold board_addr unchanged for out-of-board pixels.
REQ-022 SHALL register sprite_addr = {code, off_y, off_x} at E3, using the board_data returned for that pixel.
REQ-023 SHALL substitute code 0 when blink_en=1, phase=0 and board_data==blink_code.
REQ-024 SHALL register rgb and rgb_valid at E5, giving a fixed latency of 5 edges with no stalls.
REQ-025 SHALL accept one pixel per cycle.
REQ-026 SHALL propagate pix_valid=0 as a bubble, with rgb_valid=0 and rgb held.
REQ-027 SHALL output rgb = BG_COLOR for an out-of-board pixel, with rgb_valid=1.
REQ-028 SHALL output rgb = HL_COLOR when hl_en=1, (col,row)==(hl_col,hl_row), and off_x or off_y is 0 or 2^TILE_LOG2-1.
REQ-029 SHALL output rgb = sprite_data for all other in-board pixels.
REQ-030 SHALL sample hl_* and blink_* with the pixel at E0 and carry them down the pipeline, so that mid-flight changes do not affect that pixel.
REQ-031 SHALL maintain a BLINK_LOG2-bit frame counter that increments on frame_start and wraps to 0.
REQ-032 SHALL toggle phase when frame_start arrives while the counter is at all-ones.
REQ-033 SHALL keep the counter at 0 and phase at 1 while blink_en=0.

Reset
REQ-034 SHALL, while rst=1 at an edge, clear every pipeline valid and set rgb=BG_COLOR, rgb_valid=0, board_addr=0, sprite_addr=0, counter=0 and phase=1.
REQ-035 SHALL discard in-flight pixels on reset, so rgb_valid stays 0 until 5 edges after the first pixel sampled post-reset.
REQ-036 SHALL give rst priority over frame_start and pix_valid in the same cycle.

Verification
REQ-037 SHALL cover: rst high for 1 cycle -> rgb=3'b111, rgb_valid=0, board_addr=0 after the edge.
REQ-038 SHALL cover: pixel (176,32) at E0, with board_data=2'b01 -> board_addr=0 at E1, sprite_addr=12'h400 at E3, rgb=sprite_data at E5.
REQ-039 SHALL cover: pixel (495,351) -> board_addr=99; pixel (496,351) -> rgb=3'b111 with rgb_valid=1 at E5, and board_addr unchanged.
REQ-040 SHALL cover: hl_en=1, hl_col=3, hl_row=2; pixel (272,96) -> rgb=3'b100; pixel (273,97) -> rgb=sprite_data.
REQ-041 SHALL cover: BLINK_LOG2=1, blink_en=1, blink_code=2'b10, 2 frame_start pulses, then a tile with code 10 -> sprite_addr code field=00, and code field=10 after 2 more pulses.
REQ-042 SHALL cover: a continuous pixel stream with rst asserted mid-stream -> rgb_valid=0 for the reset cycle plus 5 edges, then correct rgb resumes.

Source files
------------

// File: rtl/board_pixel_pipeline.sv
// Tile-board pixel pipeline: maps a screen pixel to a board cell, fetches the
// cell code and its sprite texel, and applies highlight/blink/background rules.
module board_pixel_pipeline #(
  parameter int unsigned COLS       = 10,
  parameter int unsigned ROWS       = 10,
  parameter int unsigned TILE_LOG2  = 5,
  parameter int unsigned ORG_X      = 176,
  parameter int unsigned ORG_Y      = 32,
  parameter int unsigned CW         = 2,
  parameter int unsigned RGB_W      = 3,
  parameter logic [RGB_W-1:0] BG_COLOR = 3'b111,
  parameter logic [RGB_W-1:0] HL_COLOR = 3'b100,
  parameter int unsigned BLINK_LOG2 = 4,
  localparam int unsigned AW = $clog2(COLS*ROWS),
  localparam int unsigned SW = CW + 2*TILE_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic             frame_start,
  output logic [AW-1:0]    board_addr,
  input  logic [CW-1:0]    board_data,
  output logic [SW-1:0]    sprite_addr,
  input  logic [RGB_W-1:0] sprite_data,
  input  logic             hl_en,
  input  logic [7:0]       hl_col,
  input  logic [7:0]       hl_row,
  input  logic             blink_en,
  input  logic [CW-1:0]    blink_code,
  output logic [RGB_W-1:0] rgb,
  output logic             rgb_valid
);

  localparam int unsigned TILE = 1 << TILE_LOG2;
  localparam int unsigned X_HI = ORG_X + COLS*TILE;
  localparam int unsigned Y_HI = ORG_Y + ROWS*TILE;
  localparam logic [TILE_LOG2-1:0] OFF_MAX = '1;

  // blink timebase
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  phase;

  // E0: sampled request and side-band controls
  logic                  v0, hl_en0, ble0, ph0;
  logic [15:0]           x0, y0;
  logic [7:0]            hl_col0, hl_row0;
  logic [CW-1:0]         blc0;

  // E1/E2: tile-decoded pixel waiting on board RAM
  logic                  v1, in1, hl1, ble1, ph1;
  logic                  v2, in2, hl2, ble2, ph2;
  logic [TILE_LOG2-1:0]  ox1, oy1, ox2, oy2;
  logic [CW-1:0]         blc1, blc2;

  // E3/E4: waiting on sprite ROM
  logic                  v3, in3, hl3;
  logic                  v4, in4, hl4;

  logic [15:0]           dx, dy, col, row;
  logic [TILE_LOG2-1:0]  ox_c, oy_c;
  logic                  in_c, hl_c;
  logic [AW-1:0]         addr_c;
  logic [CW-1:0]         code_c;

  // cell decode of the sampled pixel
  always_comb begin
    dx     = x0 - 16'(ORG_X);
    dy     = y0 - 16'(ORG_Y);
    col    = dx >> TILE_LOG2;
    row    = dy >> TILE_LOG2;
    ox_c   = dx[TILE_LOG2-1:0];
    oy_c   = dy[TILE_LOG2-1:0];
    in_c   = (32'(x0) >= ORG_X) && (32'(x0) < X_HI) &&
             (32'(y0) >= ORG_Y) && (32'(y0) < Y_HI);
    addr_c = AW'(32'(row) * COLS + 32'(col));
    hl_c   = hl_en0 && (col == 16'(hl_col0)) && (row == 16'(hl_row0)) &&
             (ox_c == '0 || ox_c == OFF_MAX || oy_c == '0 || oy_c == OFF_MAX);
    code_c = (ble2 && !ph2 && board_data == blc2) ? '0 : board_data;
  end

  // frame counter; phase flips on the wrap of the counter
  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      frame_cnt <= '0;
      phase     <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == '1) phase <= ~phase;
      frame_cnt <= frame_cnt + BLINK_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      v4          <= 1'b0;
      board_addr  <= '0;
      sprite_addr <= '0;
      rgb         <= BG_COLOR;
      rgb_valid   <= 1'b0;
    end else begin
      v0      <= pix_valid;
      x0      <= x;
      y0      <= y;
      hl_en0  <= hl_en;
      hl_col0 <= hl_col;
      hl_row0 <= hl_row;
      ble0    <= blink_en;
      blc0    <= blink_code;
      ph0     <= phase;

      v1   <= v0;
      in1  <= in_c;
      hl1  <= hl_c;
      ox1  <= ox_c;
      oy1  <= oy_c;
      ble1 <= ble0;
      blc1 <= blc0;
      ph1  <= ph0;
      if (v0 && in_c) board_addr <= addr_c;

      v2   <= v1;
      in2  <= in1;
      hl2  <= hl1;
      ox2  <= ox1;
      oy2  <= oy1;
      ble2 <= ble1;
      blc2 <= blc1;
      ph2  <= ph1;

      v3  <= v2;
      in3 <= in2;
      hl3 <= hl2;
      if (v2 && in2) sprite_addr <= {code_c, oy2, ox2};

      v4  <= v3;
      in4 <= in3;
      hl4 <= hl3;

      // bubbles leave rgb untouched
      rgb_valid <= v4;
      if (v4) rgb <= !in4 ? BG_COLOR : (hl4 ? HL_COLOR : sprite_data);
    end
  end

endmodule

// File: tb/tb_board_pixel_pipeline.sv
// Scoreboarded directed bench for board_pixel_pipeline with board RAM and
// sprite ROM behavioural models (1-cycle read latency).
module tb_board_pixel_pipeline;

  logic        clk = 1'b0;
  logic        rst, pix_valid, frame_start, hl_en, blink_en;
  logic [15:0] x, y;
  logic [6:0]  board_addr;
  logic [1:0]  board_data, blink_code;
  logic [11:0] sprite_addr;
  logic [2:0]  sprite_data, rgb;
  logic [7:0]  hl_col, hl_row;
  logic        rgb_valid;

  logic [1:0]  mem [0:127];
  logic [2:0]  exp_q [$];
  int          n_chk = 0;
  int          n_err = 0;
  bit          ph_exp = 1'b1;
  logic [11:0] sa;
  logic [6:0]  ba;

  board_pixel_pipeline #(.BLINK_LOG2(1)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .x(x), .y(y),
    .frame_start(frame_start), .board_addr(board_addr), .board_data(board_data),
    .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .hl_en(hl_en), .hl_col(hl_col), .hl_row(hl_row),
    .blink_en(blink_en), .blink_code(blink_code),
    .rgb(rgb), .rgb_valid(rgb_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] spr(logic [11:0] a);
    return a[2:0] ^ a[7:5] ^ {1'b0, a[11:10]};
  endfunction

  always_ff @(posedge clk) begin
    board_data  <= mem[board_addr];
    sprite_data <= spr(sprite_addr);
  end

  function automatic logic [2:0] exp_rgb(int px, int py, bit ph);
    int col, row, ox, oy;
    logic [1:0] code;
    if (!(px >= 176 && px < 496 && py >= 32 && py < 352)) return 3'b111;
    col = (px - 176) / 32;  ox = (px - 176) % 32;
    row = (py - 32) / 32;   oy = (py - 32) % 32;
    if (hl_en && col == int'(hl_col) && row == int'(hl_row) &&
        (ox == 0 || ox == 31 || oy == 0 || oy == 31)) return 3'b100;
    code = mem[row*10 + col];
    if (blink_en && !ph && code == blink_code) code = 2'b00;
    return spr({code, 5'(oy), 5'(ox)});
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock edge, then score any output pixel
  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (rgb_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(rgb_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rgb", 32'(rgb), 32'(e));
      end
    end
  endtask

  task automatic pix(int px, int py);
    pix_valid = 1'b1;
    x = 16'(px);
    y = 16'(py);
    exp_q.push_back(exp_rgb(px, py, ph_exp));
  endtask

  task automatic drain();
    pix_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // single pixel with bubbles around it; captures E1 board_addr and E3 sprite_addr
  task automatic lone(int px, int py, output logic [11:0] sa_o, output logic [6:0] ba_o);
    pix(px, py);
    step();
    pix_valid = 1'b0;
    step();
    ba_o = board_addr;
    step();
    step();
    sa_o = sprite_addr;
    step();
    step();
    chk("e5_latency", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 2'(i * 7 + i / 10);
    mem[0]  = 2'b01;
    mem[11] = 2'b10;
    rst = 1'b1; pix_valid = 1'b0; x = '0; y = '0; frame_start = 1'b0;
    hl_en = 1'b0; hl_col = '0; hl_row = '0; blink_en = 1'b0; blink_code = '0;

    step();
    chk("reset_rgb", 32'(rgb), 32'h7);
    chk("reset_valid", 32'(rgb_valid), 32'd0);
    chk("reset_board_addr", 32'(board_addr), 32'd0);
    chk("reset_sprite_addr", 32'(sprite_addr), 32'd0);
    rst = 1'b0;
    step();

    lone(176, 32, sa, ba);
    chk("origin_board_addr", 32'(ba), 32'd0);
    chk("origin_sprite_addr", 32'(sa), 32'h400);

    // last in-board pixel, then first pixel past the right edge
    pix(495, 351);
    step();
    pix(496, 351);
    step();
    chk("corner_board_addr", 32'(board_addr), 32'd99);
    pix_valid = 1'b0;
    step();
    chk("outside_holds_addr", 32'(board_addr), 32'd99);
    chk("outside_expect_bg", 32'(exp_rgb(496, 351, ph_exp)), 32'h7);
    drain();

    // highlight border, interior, then a change while the pixel is in flight
    hl_en = 1'b1; hl_col = 8'd3; hl_row = 8'd2;
    chk("hl_expect", 32'(exp_rgb(272, 96, ph_exp)), 32'h4);
    pix(272, 96);
    step();
    pix(273, 97);
    step();
    pix(303, 110);
    step();
    hl_en = 1'b0;
    pix_valid = 1'b0;
    step();
    drain();

    // blink: two pulses flip the phase off, two more bring it back
    blink_en = 1'b1; blink_code = 2'b10;
    step();
    pulse();
    pulse();
    ph_exp = 1'b0;
    lone(213, 71, sa, ba);
    chk("blink_board_addr", 32'(ba), 32'd11);
    chk("blink_code_off", 32'(sa[11:10]), 32'd0);
    chk("blink_offsets", 32'(sa[9:0]), 32'h0E5);
    pulse();
    pulse();
    ph_exp = 1'b1;
    lone(213, 71, sa, ba);
    chk("blink_code_on", 32'(sa[11:10]), 32'd2);
    blink_en = 1'b0;
    step();

    // continuous stream with bubbles, reset mid-stream
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 4) pix_valid = 1'b0;
      else pix(170 + i * 17, 28 + i * 19);
      step();
    end
    rst = 1'b1; pix_valid = 1'b1; x = 16'd200; y = 16'd100;
    step();
    chk("midrst_valid", 32'(rgb_valid), 32'd0);
    chk("midrst_rgb", 32'(rgb), 32'h7);
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pix(180 + i * 29, 40 + i * 27);
      step();
      if (i < 5) chk("midrst_gap", 32'(rgb_valid), 32'd0);
      if (i == 5) chk("midrst_resume", 32'(rgb_valid), 32'd1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
